// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with a 2-FF input synchroniser, a byte push
// strobe per valid frame, a frame-error strobe on a bad stop bit, and break handling.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       rx_pin,
    output logic       uart_push,
    output logic [7:0] uart_data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic             r_sync1;
    logic             r_rx_s;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_push;
    logic             r_err;
    logic             r_busy;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_push_nxt;
    logic             w_err_nxt;

    // Synchroniser for the asynchronous line; idles high out of reset
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_pin;
            r_rx_s  <= r_sync1;
        end
    end

    // Next-state, bit timing and output decisions; the counter restarts on every state entry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_push_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_push_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_push    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_push    <= w_push_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign uart_push = r_push;
    assign uart_data = r_data;
    assign frame_err = r_err;
    assign rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a fast instance (8 clocks/bit) for most
// scenarios and a 434 clocks/bit instance for back-to-back command bytes.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int CPB_A  = 8;
    localparam int CPB_B  = 434;
    localparam int HALF_A = (CPB_A - 1) / 2;
    // pin fall just after edge E0 -> t0 = E3; push visible after edge t0+1+HALF+9*CPB
    localparam int T_PUSH = 3 + 1 + HALF_A + 9 * CPB_A;
    localparam realtime CLK_NS = 10.0;

    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    logic rx_a   = 1'b1;
    logic rx_b   = 1'b1;

    logic       push_a, err_a, busy_a;
    logic [7:0] data_a;
    logic       push_b, err_b, busy_b;
    logic [7:0] data_b;

    always #5 in_clk = ~in_clk;

    uart_rx_frame #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .in_clk(in_clk), .in_rst(in_rst), .rx_pin(rx_a),
        .uart_push(push_a), .uart_data(data_a), .frame_err(err_a), .rx_busy(busy_a)
    );

    uart_rx_frame #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .in_clk(in_clk), .in_rst(in_rst), .rx_pin(rx_b),
        .uart_push(push_b), .uart_data(data_b), .frame_err(err_b), .rx_busy(busy_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling edge
    int         n_push_a = 0;
    int         n_err_a  = 0;
    int         n_both   = 0;
    int         n_err_b  = 0;
    logic [7:0] got_b[$];

    always @(negedge in_clk) begin
        if (push_a) n_push_a++;
        if (err_a) n_err_a++;
        if ((push_a && err_a) || (push_b && err_b)) n_both++;
        if (push_b) got_b.push_back(data_b);
        if (err_b) n_err_b++;
    end

    task automatic send_frame(input bit line, input logic [7:0] b, input logic stop,
                              input realtime bit_ns);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (line) rx_b = fr[i];
            else rx_a = fr[i];
            #(bit_ns);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_push;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0, e0;
        logic [7:0] exp_b[3];
        logic [7:0] gv;
        realtime    per[2];

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h11, 1'b1, 1, 0, 8'h11};
        vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[5] = '{8'h80, 1'b0, 0, 1, 8'hFF};
        vecs[6] = '{8'h01, 1'b1, 1, 0, 8'h01};
        exp_b   = '{8'h40, 8'h9B, 8'hC0};
        per     = '{CPB_A * CLK_NS * 1.03, CPB_A * CLK_NS * 0.97};

        // Reset values
        repeat (5) @(posedge in_clk);
        #1 in_rst = 1'b0;
        check("rst_push", 32'(push_a), 32'(0));
        check("rst_err", 32'(err_a), 32'(0));
        check("rst_data", 32'(data_a), 32'(0));
        check("rst_busy", 32'(busy_a), 32'(0));
        repeat (4) @(posedge in_clk);

        // Single frame with exact strobe timing
        @(posedge in_clk);
        #1;
        p0 = n_push_a;
        e0 = n_err_a;
        fork
            send_frame(1'b0, 8'hA5, 1'b1, CPB_A * CLK_NS);
            begin
                repeat (2) @(posedge in_clk);
                #1 check("busy_before_t0", 32'(busy_a), 32'(0));
                @(posedge in_clk);
                #1 check("busy_after_t0", 32'(busy_a), 32'(1));
                repeat (T_PUSH - 4) @(posedge in_clk);
                #1 check("push_early", 32'(push_a), 32'(0));
                @(posedge in_clk);
                #1 check("push_on_time", 32'(push_a), 32'(1));
                check("data_on_time", 32'(data_a), 32'(8'hA5));
                check("busy_falls", 32'(busy_a), 32'(0));
                @(posedge in_clk);
                #1 check("push_one_cycle", 32'(push_a), 32'(0));
            end
        join
        repeat (8) @(posedge in_clk);
        check("single_push_cnt", 32'(n_push_a - p0), 32'(1));
        check("single_err_cnt", 32'(n_err_a - e0), 32'(0));

        // Table of frames with good and bad stop bits
        for (int v = 0; v < 7; v++) begin
            p0 = n_push_a;
            e0 = n_err_a;
            @(posedge in_clk);
            #1 send_frame(1'b0, vecs[v].data, vecs[v].stop, CPB_A * CLK_NS);
            rx_a = 1'b1;
            repeat (16) @(posedge in_clk);
            #1;
            check($sformatf("vec%0d_push", v), 32'(n_push_a - p0), 32'(vecs[v].exp_push));
            check($sformatf("vec%0d_err", v), 32'(n_err_a - e0), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_data", v), 32'(data_a), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_busy", v), 32'(busy_a), 32'(0));
        end

        // Two-cycle glitch is rejected
        p0 = n_push_a;
        e0 = n_err_a;
        @(posedge in_clk);
        #1 rx_a = 1'b0;
        repeat (2) @(posedge in_clk);
        #1 rx_a = 1'b1;
        repeat (2) @(posedge in_clk);
        #1 check("glitch_busy_high", 32'(busy_a), 32'(1));
        repeat (20) @(posedge in_clk);
        #1 check("glitch_busy_low", 32'(busy_a), 32'(0));
        check("glitch_no_push", 32'(n_push_a - p0), 32'(0));
        check("glitch_no_err", 32'(n_err_a - e0), 32'(0));

        // Break: 30 bit times low
        p0 = n_push_a;
        e0 = n_err_a;
        @(posedge in_clk);
        #1 rx_a = 1'b0;
        repeat (30 * CPB_A) @(posedge in_clk);
        #1;
        check("break_busy", 32'(busy_a), 32'(1));
        check("break_one_err", 32'(n_err_a - e0), 32'(1));
        check("break_no_push", 32'(n_push_a - p0), 32'(0));
        rx_a = 1'b1;
        repeat (6) @(posedge in_clk);
        #1 check("break_released", 32'(busy_a), 32'(0));
        check("break_err_total", 32'(n_err_a - e0), 32'(1));

        // Reset during data bit 4 of 8'hFF, then a clean 8'h5A
        check("pre_rst_data", 32'(data_a), 32'(8'h01));
        p0 = n_push_a;
        @(posedge in_clk);
        #1;
        fork
            send_frame(1'b0, 8'hFF, 1'b1, CPB_A * CLK_NS);
            begin
                #(CPB_A * CLK_NS * 5.5);
                @(posedge in_clk);
                #1 in_rst = 1'b1;
                @(posedge in_clk);
                #1 in_rst = 1'b0;
                check("midrst_push", 32'(push_a), 32'(0));
                check("midrst_err", 32'(err_a), 32'(0));
                check("midrst_data", 32'(data_a), 32'(0));
                check("midrst_busy", 32'(busy_a), 32'(0));
            end
        join
        repeat (16) @(posedge in_clk);
        check("midrst_no_push", 32'(n_push_a - p0), 32'(0));
        @(posedge in_clk);
        #1 send_frame(1'b0, 8'h5A, 1'b1, CPB_A * CLK_NS);
        repeat (16) @(posedge in_clk);
        check("after_rst_push", 32'(n_push_a - p0), 32'(1));
        check("after_rst_data", 32'(data_a), 32'(8'h5A));

        // Back-to-back command bytes at 434 clocks/bit
        @(posedge in_clk);
        #1;
        for (int i = 0; i < 3; i++) send_frame(1'b1, exp_b[i], 1'b1, CPB_B * CLK_NS);
        repeat (2 * CPB_B) @(posedge in_clk);
        check("b2b_count", 32'(got_b.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            gv = (i < got_b.size()) ? got_b[i] : 8'hxx;
            check($sformatf("b2b_byte%0d", i), 32'(gv), 32'(exp_b[i]));
        end
        check("b2b_no_err", 32'(n_err_b), 32'(0));

        // Baud tolerance: +3% then -3% bit period, all 256 values
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) begin
                p0 = n_push_a;
                e0 = n_err_a;
                send_frame(1'b0, 8'(i), 1'b1, per[s]);
                #(per[s]);
                check($sformatf("baud%0d_push_%02h", s, i), 32'(n_push_a - p0), 32'(1));
                check($sformatf("baud%0d_data_%02h", s, i), 32'(data_a), 32'(i));
                check($sformatf("baud%0d_err_%02h", s, i), 32'(n_err_a - e0), 32'(0));
            end
        end

        check("strobes_exclusive", 32'(n_both), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receiver that converts the serial RX pin into the byte stream consumed by the control FSM. Delivers an 8-bit byte with a one-cycle `uart_push` strobe per valid 8N1 frame; the FSM decodes the top two bits as the command field. Frames with a bad stop bit are dropped and flagged. Single clock domain; the asynchronous RX pin is synchronised internally.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200). Clock cycles per bit; legal range 4..65535.
- `in_clk`  input  1  system clock.
- `in_rst`  input  1  synchronous, active-high reset.
- `rx_pin`  input  1  asynchronous serial line; idle high.
- `uart_push`  output  1  one-cycle strobe: `uart_data` holds a new valid byte.
- `uart_data`  output  8  last valid byte, LSB received first; held until the next valid frame.
- `frame_err`  output  1  one-cycle strobe: stop bit sampled low, byte discarded.
- `rx_busy`  output  1  high in any state other than IDLE.

## Operation
- **Reset and synchronisation**
  - Reset is synchronous and active-high; the clock is the only clock.
  - `rx_pin` passes through a 2-FF synchroniser (`rx_s`); both flops reset to 1.
  - All logic uses `rx_s` only.
- **Shared bit counter:** `cnt` is wide enough for `CLKS_PER_BIT-1`, resets to 0 on every state entry, and increments each cycle. `HALF` = (`CLKS_PER_BIT`-1)/2, integer division.
- **States**
  - IDLE:
    - `rx_s`=0 → START.
  - START:
    - At `cnt`==`HALF`, sample `rx_s`. 0 → DATA with bit index 0. 1 → IDLE (glitch rejected, no strobes).
  - DATA:
    - At `cnt`==`CLKS_PER_BIT`-1, shift `rx_s` into the shift register at MSB, shifting right, so LSB-first ends correctly ordered.
    - After the 8th sample → STOP; otherwise stay in DATA with `cnt` restarted.
  - STOP:
    - At `cnt`==`CLKS_PER_BIT`-1, sample `rx_s`.
    - 1 → load `uart_data` from the shift register, pulse `uart_push`, → IDLE.
    - 0 → pulse `frame_err`, leave `uart_data` unchanged, → BREAK.
  - BREAK:
    - Wait for `rx_s`=1, then → IDLE. A held-low line (break) produces exactly one `frame_err` and no further frames.
- **Concurrency and reset**
  - The receiver never stalls. The downstream consumer must take the byte on the `uart_push` cycle; no backpressure exists.
  - `in_rst` mid-frame: the next cycle is IDLE with all outputs at reset values, and the partial byte is discarded. A line still low after reset is treated as a new start bit.
- **Strobes:** `uart_push` and `frame_err` are never high in the same cycle.

## Timing
- **Reset values:** `uart_push`=0, `frame_err`=0, `uart_data`=8'h00, `rx_busy`=0, state IDLE, `cnt`=0, synchroniser flops=1.
- **t0** = clock edge at which IDLE sees `rx_s`=0.
  - State is START from t0+1.
  - Start-bit sample at edge t0+1+`HALF`.
  - Data bit k (k=0..7) sampled at t0+1+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at t0+1+`HALF`+9·`CLKS_PER_BIT`.
- **Strobe timing:** `uart_push` or `frame_err` is high for exactly the one cycle after the stop sample, and `uart_data` updates on that same edge. The state returns to IDLE on that edge.
- **rx_pin to t0:** 2 to 3 cycles after the pin falls, from synchroniser latency.
- **`rx_busy`:** rises the cycle after t0; falls with the strobe.
- **Back-to-back frames:** a start bit immediately following the stop bit is detected; total frame cost is < 10·`CLKS_PER_BIT`+3 cycles, so no byte is lost at full line rate.
- **Output drive:** all outputs are registered.

## Test plan
- **Single valid frame:** `CLKS_PER_BIT`=8, send 8'hA5 as 8N1 → exactly one `uart_push`, `uart_data`=8'hA5 at the cycle given by the formula above, `frame_err` never high, `rx_busy` low afterwards.
- **Command bytes to the FSM:** `CLKS_PER_BIT`=434, send 8'h40, 8'h9B, 8'hC0 back-to-back with no idle time → three pushes with `uart_data` 8'h40, 8'h9B, 8'hC0 in order, no errors.
- **Framing error:** send 8'h3C with the stop bit driven low, then a valid 8'h11 → one `frame_err`, no push for 8'h3C, `uart_data` stays at the previous value; then a push with 8'h11.
- **Glitch and break:**
  - A 2-cycle low pulse on `rx_pin` (`CLKS_PER_BIT`=8) → returns to IDLE, no strobes.
  - Holding the line low for 30 bit times → exactly one `frame_err`, `rx_busy` high until the line returns high.
- **Reset mid-frame:** assert `in_rst` for 1 cycle during data bit 4 of 8'hFF → next cycle all outputs at reset values. A subsequent full 8'h5A frame is received correctly with one push.
- **Baud tolerance:** drive the line at a bit period of `CLKS_PER_BIT`·1.03, then at ·0.97, sending the 256 byte values 8'h00–8'hFF → all 256 received correctly.
